// File: rtl/spi_slave_if.sv
// spi_slave_if -- bus bundle for the SPI slave.
//   slave  modport : seen from the SPI slave core
//   master modport : seen from the host/testbench side
// Signals:
//   i_spi_mode  [1]=CPOL, [0]=CPHA, held static while CS_n is low
//   i_TX_Byte / i_TX_DV / o_TX_Ready / o_TX_Underrun   transmit holding path
//   o_RX_DV / o_RX_Byte / o_RX_Count                    receive path
//   i_SPI_Clk / i_SPI_MOSI / i_SPI_CS_n                 raw pins from the master
interface spi_slave_if;
    logic [1:0] i_spi_mode;
    logic [7:0] i_TX_Byte;
    logic       i_TX_DV;
    logic       o_TX_Ready;
    logic       o_TX_Underrun;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic [3:0] o_RX_Count;
    logic       i_SPI_Clk;
    logic       i_SPI_MOSI;
    logic       i_SPI_CS_n;

    modport slave (
        input  i_spi_mode, i_TX_Byte, i_TX_DV, i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n,
        output o_TX_Ready, o_TX_Underrun, o_RX_DV, o_RX_Byte, o_RX_Count
    );

    modport master (
        output i_spi_mode, i_TX_Byte, i_TX_DV, i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n,
        input  o_TX_Ready, o_TX_Underrun, o_RX_DV, o_RX_Byte, o_RX_Count
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave -- SPI slave, all four modes selected at run time, oversampled
// on i_Clk (i_Clk must be at least 8x SCLK).
// Ports:
//   i_Clk       system clock, rising edge
//   i_Rst       synchronous active-high reset
//   bus         spi_slave_if.slave (mode, TX holding handshake, RX outputs,
//               raw SPI inputs)
//   o_SPI_MISO  serial data out, high-Z while raw CS_n is high
module spi_slave (
    input  logic       i_Clk,
    input  logic       i_Rst,
    spi_slave_if.slave bus,
    output logic       o_SPI_MISO
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t state_q, state_d;

    logic cpol, cpha;
    assign cpol = bus.i_spi_mode[1];
    assign cpha = bus.i_spi_mode[0];

    // Synchronizers; sclk_d is the extra flop for edge detection.
    logic sclk_meta, sclk_sync, sclk_d;
    logic cs_meta, cs_sync;
    logic mosi_meta, mosi_sync;

    // vld_pipe[1] marks cs_sync as carrying a real pin sample rather than
    // its reset value. armed is set only once a real CS_n high has been seen,
    // so a reset in the middle of a transaction cannot fake a CS_n fall.
    logic [1:0] vld_pipe;
    logic       armed;

    // Datapath state
    logic [2:0] bit_cnt;
    logic [3:0] byte_cnt;
    logic [7:0] rx_sh;
    logic [7:0] tx_sh;
    logic [7:0] tx_cur;     // byte currently in tx_sh, kept for hand-back on abort
    logic       tx_unfin;   // tx_sh holds a real byte not yet fully clocked out
    logic       load_pend;  // next toggle edge loads instead of shifting
    logic [7:0] hold_q;
    logic       hold_full;

    logic       rx_dv_q, urun_q;
    logic [7:0] rx_byte_q;
    logic [3:0] rx_cnt_q;

    // Edge decode on the synchronized clock
    logic lead, trail, sample_edge, toggle_edge;
    assign lead        = (sclk_d == cpol) && (sclk_sync != cpol);
    assign trail       = (sclk_d != cpol) && (sclk_sync == cpol);
    assign sample_edge = cpha ? trail : lead;
    assign toggle_edge = cpha ? lead  : trail;

    logic enter, leave, do_sample, do_toggle;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Edges reach the datapath only in SHIFT and only while CS_n stays low.
    always_comb begin
        state_d   = state_q;
        enter     = 1'b0;
        leave     = 1'b0;
        do_sample = 1'b0;
        do_toggle = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed && !cs_sync) begin
                    state_d = SHIFT;
                    enter   = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_sync) begin
                    state_d = IDLE;
                    leave   = 1'b1;
                end else begin
                    do_sample = sample_edge;
                    do_toggle = toggle_edge;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // TX load decode. CPHA=0 must present bit 7 before the first edge, so it
    // loads on entry; CPHA=1 loads on the first toggle edge of every byte.
    logic       tx_load, tx_shift, byte_done, load_real, restore;
    logic [7:0] load_byte;
    assign tx_load   = (enter && !cpha) || (do_toggle && load_pend);
    assign tx_shift  = do_toggle && !load_pend;
    assign byte_done = do_sample && (bit_cnt == 3'd7);
    assign load_real = hold_full || bus.i_TX_DV;
    assign load_byte = hold_full   ? hold_q        :
                       bus.i_TX_DV ? bus.i_TX_Byte : 8'h00;
    // An aborted byte goes back into an empty holding register so the next
    // transaction still returns it; a new write in the same cycle wins.
    assign restore   = leave && tx_unfin && !hold_full && !bus.i_TX_DV;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sclk_meta <= cpol;
            sclk_sync <= cpol;
            sclk_d    <= cpol;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            vld_pipe  <= 2'b00;
            armed     <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 4'd0;
            rx_sh     <= 8'h00;
            tx_sh     <= 8'h00;
            tx_cur    <= 8'h00;
            tx_unfin  <= 1'b0;
            load_pend <= 1'b0;
            hold_q    <= 8'h00;
            hold_full <= 1'b0;
            rx_dv_q   <= 1'b0;
            urun_q    <= 1'b0;
            rx_byte_q <= 8'h00;
            rx_cnt_q  <= 4'h0;
        end else begin
            sclk_meta <= bus.i_SPI_Clk;
            sclk_sync <= sclk_meta;
            sclk_d    <= sclk_sync;
            cs_meta   <= bus.i_SPI_CS_n;
            cs_sync   <= cs_meta;
            mosi_meta <= bus.i_SPI_MOSI;
            mosi_sync <= mosi_meta;
            vld_pipe  <= {vld_pipe[0], 1'b1};
            if (vld_pipe[1] && cs_sync) armed <= 1'b1;

            rx_dv_q <= 1'b0;
            urun_q  <= 1'b0;

            if (enter) begin
                bit_cnt   <= 3'd0;
                byte_cnt  <= 4'd0;
                rx_sh     <= 8'h00;
                load_pend <= cpha;
            end

            if (leave) tx_unfin <= 1'b0;

            if (do_sample) begin
                rx_sh   <= {rx_sh[6:0], mosi_sync};
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                    rx_byte_q <= {rx_sh[6:0], mosi_sync};
                    rx_cnt_q  <= byte_cnt;
                    rx_dv_q   <= 1'b1;
                    byte_cnt  <= byte_cnt + 4'd1;
                    load_pend <= 1'b1;
                    tx_unfin  <= 1'b0;
                end
            end

            if (tx_load) begin
                tx_sh    <= load_byte;
                tx_cur   <= load_byte;
                tx_unfin <= load_real;
                urun_q   <= !load_real;
                if (do_toggle) load_pend <= 1'b0;
            end else if (tx_shift) begin
                tx_sh <= {tx_sh[6:0], 1'b0};
            end

            // Holding register: a load drains it; a direct-load write
            // bypasses it; otherwise accept a write while empty.
            if (tx_load) begin
                if (hold_full) hold_full <= 1'b0;
            end else if (bus.i_TX_DV && !hold_full) begin
                hold_q    <= bus.i_TX_Byte;
                hold_full <= 1'b1;
            end else if (restore) begin
                hold_q    <= tx_cur;
                hold_full <= 1'b1;
            end
        end
    end

    assign bus.o_TX_Ready    = !hold_full;
    assign bus.o_TX_Underrun = urun_q;
    assign bus.o_RX_DV       = rx_dv_q;
    assign bus.o_RX_Byte     = rx_byte_q;
    assign bus.o_RX_Count    = rx_cnt_q;

    assign o_SPI_MISO = bus.i_SPI_CS_n ? 1'bz : tx_sh[7];

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave -- randomized + directed bench for spi_slave. A bit-level SPI
// master drives the pins; expectations come from transaction-level rules
// (bytes returned, RX index sequence, number of byte loads vs. bytes available).
module tb_spi_slave;

    localparam int H = 8;  // half SCLK period in i_Clk cycles (16x ratio)

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b1;
    wire  spi_miso;

    spi_slave_if bus();

    spi_slave dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .bus        (bus),
        .o_SPI_MISO (spi_miso)
    );

    always #5 i_Clk = ~i_Clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic        cpol = 1'b0, cpha = 1'b0;
    logic [31:0] mi_w;

    // Monitor: accumulates RX pulses and underrun pulses; tests use deltas.
    logic [11:0] rx_q[$];
    int          urun = 0;

    always @(negedge i_Clk) begin
        if (bus.o_RX_DV)       rx_q.push_back({bus.o_RX_Count, bus.o_RX_Byte});
        if (bus.o_TX_Underrun) urun++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic set_mode(input logic [1:0] m);
        bus.i_spi_mode = m;
        cpol = m[1];
        cpha = m[0];
        bus.i_SPI_Clk = m[1];
    endtask

    task automatic do_reset();
        i_Rst = 1'b1;
        wait_clk(2);
        i_Rst = 1'b0;
        wait_clk(4);
    endtask

    task automatic write_on_ready(input string tag, input logic [7:0] b);
        int t = 0;
        while (!bus.o_TX_Ready && t < 4000) begin
            wait_clk(1);
            t++;
        end
        chk({tag, "_wr_timeout"}, 32'(t < 4000), 32'd1);
        bus.i_TX_Byte = b;
        bus.i_TX_DV   = 1'b1;
        wait_clk(1);
        bus.i_TX_DV   = 1'b0;
    endtask

    task automatic cs_low();
        bus.i_SPI_Clk  = cpol;
        bus.i_SPI_CS_n = 1'b0;
        wait_clk(2 * H);
    endtask

    task automatic cs_high();
        wait_clk(H);
        bus.i_SPI_CS_n = 1'b1;
        wait_clk(4 * H);
    endtask

    // Clock nbits out of d, MSB first, capturing MISO into mi_w.
    task automatic clk_bits(input int nbits, input logic [31:0] d);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) bus.i_SPI_MOSI = d[31 - i];
            wait_clk(4);
            bus.i_SPI_Clk = ~cpol;
            if (cpha) bus.i_SPI_MOSI = d[31 - i];
            else      mi_w = {mi_w[30:0], spi_miso};
            wait_clk(H);
            bus.i_SPI_Clk = cpol;
            if (cpha) mi_w = {mi_w[30:0], spi_miso};
            wait_clk(H - 4);
        end
    endtask

    // Full-byte transaction against the transaction-level model:
    // byte 0 returns the preload (or 0), later bytes 0; byte loads number
    // n for CPHA=1 and n+1 for CPHA=0, each one without data is an underrun.
    task automatic run_case(input string tag, input logic [1:0] m, input bit pre,
                            input logic [7:0] p, input int n, input logic [31:0] d);
        int          rb, ub, loads;
        logic [31:0] mask, exp_mi;
        set_mode(m);
        do_reset();
        if (pre) begin
            write_on_ready(tag, p);
            chk({tag, "_rdy_pre"}, 32'(bus.o_TX_Ready), 32'd0);
        end
        rb   = rx_q.size();
        ub   = urun;
        mi_w = '0;
        cs_low();
        clk_bits(8 * n, d);
        cs_high();
        mask   = (32'h1 << (8 * n)) - 32'h1;
        exp_mi = pre ? (32'(p) << (8 * (n - 1))) : 32'h0;
        loads  = cpha ? n : n + 1;
        chk({tag, "_miso"}, mi_w & mask, exp_mi);
        chk({tag, "_rxn"}, 32'(rx_q.size() - rb), 32'(n));
        for (int k = 0; k < n; k++)
            if (rb + k < rx_q.size())
                chk({tag, "_rx"}, 32'(rx_q[rb + k]), 32'({4'(k), d[31 - 8 * k -: 8]}));
        chk({tag, "_urun"}, 32'(urun - ub), 32'(loads - (pre ? 1 : 0)));
        chk({tag, "_rdy"}, 32'(bus.o_TX_Ready), 32'd1);
    endtask

    initial begin
        int          rb, ub;
        logic [31:0] d;

        bus.i_TX_Byte  = 8'h00;
        bus.i_TX_DV    = 1'b0;
        bus.i_SPI_MOSI = 1'b0;
        bus.i_SPI_CS_n = 1'b1;
        set_mode(2'd0);

        // Reset state
        wait_clk(2);
        chk("rst_rxdv", 32'(bus.o_RX_DV), 32'd0);
        chk("rst_rdy",  32'(bus.o_TX_Ready), 32'd1);
        chk("rst_urun", 32'(bus.o_TX_Underrun), 32'd0);
        chk("rst_rxb",  32'(bus.o_RX_Byte), 32'd0);
        chk("rst_rxc",  32'(bus.o_RX_Count), 32'd0);
        i_Rst = 1'b0;
        wait_clk(4);

        // Directed: mode 0 A5/3C, modes 1..3 C3/96, mode 1 underrun
        run_case("m0_a5", 2'd0, 1'b1, 8'hA5, 1, 32'h3C00_0000);
        for (int m = 1; m < 4; m++)
            run_case("mx_c3", 2'(m), 1'b1, 8'hC3, 1, 32'h9600_0000);
        run_case("m1_urun", 2'd1, 1'b0, 8'h00, 1, {8'($urandom), 24'h0});

        // Mode 0 burst with writes on each TX_Ready
        set_mode(2'd0);
        do_reset();
        write_on_ready("burst", 8'h11);
        d    = {24'($urandom), 8'h00};
        rb   = rx_q.size();
        ub   = urun;
        mi_w = '0;
        fork
            begin
                cs_low();
                clk_bits(24, d);
                cs_high();
            end
            begin
                write_on_ready("burst", 8'h22);
                write_on_ready("burst", 8'h33);
                write_on_ready("burst", 8'h44);
            end
        join
        chk("burst_miso", mi_w & 32'h00FF_FFFF, 32'h0011_2233);
        chk("burst_rxn", 32'(rx_q.size() - rb), 32'd3);
        for (int k = 0; k < 3; k++)
            if (rb + k < rx_q.size())
                chk("burst_rx", 32'(rx_q[rb + k]), 32'({4'(k), d[31 - 8 * k -: 8]}));
        chk("burst_urun", 32'(urun - ub), 32'd0);

        // Mode 0 abort after 5 SCLK cycles, then a full transaction
        set_mode(2'd0);
        do_reset();
        write_on_ready("abort", 8'h5C);
        rb = rx_q.size();
        ub = urun;
        cs_low();
        clk_bits(5, $urandom);
        cs_high();
        chk("abort_rxn",  32'(rx_q.size() - rb), 32'd0);
        chk("abort_urun", 32'(urun - ub), 32'd0);
        chk("abort_rdy",  32'(bus.o_TX_Ready), 32'd0);
        d    = {8'($urandom), 24'h0};
        rb   = rx_q.size();
        mi_w = '0;
        cs_low();
        clk_bits(8, d);
        cs_high();
        chk("abort_miso", mi_w & 32'hFF, 32'h5C);
        chk("abort_rxn2", 32'(rx_q.size() - rb), 32'd1);
        if (rb < rx_q.size())
            chk("abort_rx", 32'(rx_q[rb]), 32'({4'd0, d[31:24]}));

        // Reset mid-transaction with CS_n held low
        run_case("pre_rst", 2'd0, 1'b0, 8'h00, 1, 32'hE700_0000);
        write_on_ready("midrst", 8'h5A);
        rb = rx_q.size();
        cs_low();
        clk_bits(4, $urandom);
        i_Rst = 1'b1;
        wait_clk(2);
        chk("midrst_rxdv", 32'(bus.o_RX_DV), 32'd0);
        chk("midrst_rdy",  32'(bus.o_TX_Ready), 32'd1);
        chk("midrst_urun", 32'(bus.o_TX_Underrun), 32'd0);
        chk("midrst_rxb",  32'(bus.o_RX_Byte), 32'd0);
        chk("midrst_rxc",  32'(bus.o_RX_Count), 32'd0);
        i_Rst = 1'b0;
        wait_clk(4);
        clk_bits(8, $urandom);
        cs_high();
        chk("midrst_norx", 32'(rx_q.size() - rb), 32'd0);
        d    = {8'($urandom), 24'h0};
        mi_w = '0;
        cs_low();
        clk_bits(8, d);
        cs_high();
        chk("midrst_rxn", 32'(rx_q.size() - rb), 32'd1);
        if (rb < rx_q.size())
            chk("midrst_rx", 32'(rx_q[rb]), 32'({4'd0, d[31:24]}));

        // Randomized transactions
        for (int it = 0; it < 12; it++)
            run_case("rnd", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     8'($urandom), int'($urandom_range(1, 3)), $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: none; SPI mode is supplied at run time on i_spi_mode.
REQ-002 i_Clk  in  1  system clock; one clock domain, rising edge only.
REQ-003 i_Rst  in  1  synchronous, active-high reset.
REQ-004 i_spi_mode  in  2  [1]=CPOL, [0]=CPHA; static while i_SPI_CS_n is low.
REQ-005 i_TX_Byte  in  8  next byte to return on MISO.
REQ-006 i_TX_DV  in  1  write strobe for i_TX_Byte; accepted only when o_TX_Ready=1.
REQ-007 o_TX_Ready  out  1  transmit holding register empty.
REQ-008 o_TX_Underrun  out  1  one-cycle pulse: byte load found the holding register empty.
REQ-009 o_RX_DV  out  1  one-cycle pulse: o_RX_Byte is valid.
REQ-010 o_RX_Byte  out  8  last complete byte received on MOSI, MSB first.
REQ-011 o_RX_Count  out  4  index of o_RX_Byte within its CS-low transaction, starting at 0.
REQ-012 i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n  in  1 each  asynchronous SPI inputs from the master.
REQ-013 o_SPI_MISO  out  1  serial data; high-Z while i_SPI_CS_n is high.

Function
REQ-014 i_SPI_Clk, i_SPI_MOSI and i_SPI_CS_n SHALL each pass through a 2-flop synchronizer; a third SCLK flop provides edge detection.
REQ-015 i_Clk SHALL be at least 8x SCLK; operation below this ratio is unsupported.
- Leading edge = synced SCLK leaving the CPOL level; trailing edge = return to it.
- Sample edge = leading edge if CPHA=0, else trailing edge.
- Toggle edge = the other edge.
REQ-016 The FSM SHALL have two states, IDLE and SHIFT. IDLE->SHIFT on synced CS_n high->low. SHIFT->IDLE on synced CS_n low->high. SCLK edges SHALL be ignored in IDLE.
REQ-017 On IDLE->SHIFT: 3-bit bit counter=0, 4-bit byte counter=0, RX shift register=0.
REQ-018 On each sample edge in SHIFT, the synced MOSI bit SHALL shift into RX shift register bit 0 and the bit counter SHALL increment, wrapping 7->0.
REQ-019 On the sample edge with bit counter=7, in the following cycle:
- o_RX_Byte = {shreg[6:0], MOSI}
- o_RX_DV = 1 for one cycle
- o_RX_Count = byte counter
- byte counter increments, wrapping 15->0.
REQ-020 The TX shift register SHALL load a new byte at these points:
- CPHA=0: the IDLE->SHIFT transition, and the first toggle edge after each completed byte.
- CPHA=1: the first toggle edge of each byte.
- At every other toggle edge in SHIFT it SHALL shift left, filling with 0.
REQ-021 Load source: the holding register if full, which then empties. If the holding register is empty and i_TX_DV=1 in the same cycle, load i_TX_Byte directly; no underrun, holding register stays empty. If empty and no i_TX_DV, load 8'h00 and pulse o_TX_Underrun.
REQ-022 Holding register write: i_TX_DV=1 with o_TX_Ready=1 captures i_TX_Byte and sets full (o_TX_Ready=0) on the next cycle. i_TX_DV while full SHALL be ignored. Writes are accepted in both IDLE and SHIFT.
REQ-023 o_SPI_MISO SHALL be TX shift register bit 7 when raw i_SPI_CS_n=0, else 1'bz.
REQ-024 CS_n deasserting with bit counter!=0 SHALL discard the partial byte: no o_RX_DV, no underrun pulse. The holding register contents SHALL be preserved.
REQ-025 o_RX_Byte and o_RX_Count SHALL hold their values until the next o_RX_DV.

Reset
REQ-026 While i_Rst=1 at a clock edge, the block SHALL set:
- FSM = IDLE
- all counters and shift registers = 0
- holding register empty, o_TX_Ready=1
- o_RX_DV=0, o_TX_Underrun=0
- o_RX_Byte=8'h00, o_RX_Count=4'h0
- synchronizer flops to SCLK=CPOL, CS_n=1, MOSI=0.
REQ-027 Reset asserted mid-transaction SHALL abort it. After release with CS_n still low, the block SHALL stay IDLE until CS_n goes high and then low again.

Verification
REQ-028 Mode 0, i_Clk=16x SCLK: preload 8'hA5, master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; o_RX_Byte=8'h3C; o_RX_Count=0; one o_RX_DV pulse.
REQ-029 Modes 1, 2 and 3, each in turn: preload 8'hC3, master sends 8'h96 -> master receives 8'hC3; o_RX_Byte=8'h96.
REQ-030 Mode 0, 3-byte burst with bytes 8'h11, 8'h22, 8'h33 written on each o_TX_Ready -> MISO carries 11 22 33; o_RX_Count=0, 1, 2; no underrun.
REQ-031 Mode 1, no preload, master sends one byte -> MISO all zeros; one o_TX_Underrun pulse; o_RX_DV still asserted.
REQ-032 Mode 0: CS_n raised after 5 SCLK cycles -> no o_RX_DV. Next full transaction returns the still-held preloaded byte with o_RX_Count=0.
REQ-033 i_Rst pulsed after bit 3 with CS_n held low -> outputs at reset values; no o_RX_DV until CS_n toggles high then low.
